// File: rtl/alu_pkg.sv
// ALU select encodings shared by the ALU, the decoder and the ALU share arbiter.
// The helper function marks which select codes the ALU actually implements.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  // Codes 1001 and 1011..1111 have no ALU implementation.
  function automatic logic alu_sel_supported(input logic [3:0] sel);
    return (sel <= ALU_SLTU) || (sel == ALU_SRA);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr_i with wrap,
// plus the pointer value that follows the granted index.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] next_ptr_o
);

  int   idx;
  logic found;

  always_comb begin
    grant_o    = '0;
    next_ptr_o = ptr_i;
    found      = 1'b0;
    idx        = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      if (!found && eligible_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        next_ptr_o   = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NREQ requesters: round-robin issue of one
// operation per cycle, with a registered result slot per requester.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_op1,
  input  logic [NREQ*XLEN-1:0] req_op2,
  input  logic [NREQ*4-1:0]    req_sel,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*XLEN-1:0] rsp_data,
  output logic [NREQ-1:0]      rsp_err,
  output logic [XLEN-1:0]      alu_inp1,
  output logic [XLEN-1:0]      alu_inp2,
  output logic [3:0]           alu_sel,
  input  logic [XLEN-1:0]      alu_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]           eligible;
  logic [NREQ-1:0]           grant;
  logic [PW-1:0]             ptr_q, ptr_d, ptr_next;
  logic [NREQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0]           rsp_err_q, rsp_err_d;
  logic [NREQ-1:0][XLEN-1:0] rsp_data_q, rsp_data_d;

  // A full slot that drains this cycle can accept a new result at once.
  assign eligible = req_valid & (~rsp_valid_q | rsp_ready);

  rr_arbiter #(.N(NREQ)) u_rr (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .next_ptr_o (ptr_next)
  );

  assign req_ready = grant & {NREQ{rst_n}};
  assign ptr_d     = (|req_ready) ? ptr_next : ptr_q;

  always_comb begin
    alu_inp1 = '0;
    alu_inp2 = '0;
    alu_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        alu_inp1 = req_op1[i*XLEN +: XLEN];
        alu_inp2 = req_op2[i*XLEN +: XLEN];
        alu_sel  = req_sel[i*4 +: 4];
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = alu_out;
        rsp_err_d[i]   = !alu_sel_supported(alu_sel);
      end else if (rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU on the alu_* port.
// Directed vectors push expected results; a negedge monitor pops them on each consume.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_op1;
  logic [NREQ*XLEN-1:0] req_op2;
  logic [NREQ*4-1:0]    req_sel;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [NREQ*XLEN-1:0] rsp_data;
  logic [NREQ-1:0]      rsp_err;
  logic [XLEN-1:0]      alu_inp1;
  logic [XLEN-1:0]      alu_inp2;
  logic [3:0]           alu_sel;
  logic [XLEN-1:0]      alu_out;

  int checks;
  int errors;
  logic [XLEN:0] expQ[NREQ][$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_inp1  (alu_inp1),
    .alu_inp2  (alu_inp2),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out)
  );

  // Reference ALU; unsupported select codes produce zero.
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      ALU_ADD:  alu_out = alu_inp1 + alu_inp2;
      ALU_SUB:  alu_out = alu_inp1 - alu_inp2;
      ALU_AND:  alu_out = alu_inp1 & alu_inp2;
      ALU_OR:   alu_out = alu_inp1 | alu_inp2;
      ALU_SLL:  alu_out = alu_inp1 << alu_inp2[4:0];
      ALU_SRL:  alu_out = alu_inp1 >> alu_inp2[4:0];
      ALU_XOR:  alu_out = alu_inp1 ^ alu_inp2;
      ALU_SLT:  alu_out = {31'b0, $signed(alu_inp1) < $signed(alu_inp2)};
      ALU_SLTU: alu_out = {31'b0, alu_inp1 < alu_inp2};
      ALU_SRA:  alu_out = $unsigned($signed(alu_inp1) >>> alu_inp2[4:0]);
      default:  alu_out = '0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [3:0] s);
    req_op1[r*XLEN +: XLEN] = a;
    req_op2[r*XLEN +: XLEN] = b;
    req_sel[r*4 +: 4]       = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every consumed response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (expQ[i].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp%0d actual=%h expected=none", i, rsp_data[i*XLEN +: XLEN]);
          end else begin
            logic [XLEN:0] e;
            e = expQ[i].pop_front();
            checkOutput($sformatf("rsp_data%0d", i), 64'(rsp_data[i*XLEN +: XLEN]), 64'(e[XLEN-1:0]));
            checkOutput($sformatf("rsp_err%0d", i), 64'(rsp_err[i]), 64'(e[XLEN]));
          end
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_op1   = '0;
    req_op2   = '0;
    req_sel   = '0;

    @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready), 64'h0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("reset_rsp_data", 64'(rsp_data), 64'h0);
    checkOutput("reset_rsp_err", 64'(rsp_err), 64'h0);

    // Single issue: ADD wraps to zero, then SRA sign-fills.
    tick();
    rst_n     = 1'b1;
    rsp_ready = 2'b11;
    req_valid = 2'b01;
    applyStimulus(0, 32'hFFFF_FFF0, 32'h0000_0010, ALU_ADD);
    @(negedge clk);
    checkOutput("add_req_ready", 64'(req_ready), 64'h1);
    checkOutput("add_alu_inp1", 64'(alu_inp1), 64'hFFFF_FFF0);
    checkOutput("add_alu_inp2", 64'(alu_inp2), 64'h10);
    checkOutput("add_alu_sel", 64'(alu_sel), 64'h0);
    expQ[0].push_back({1'b0, 32'h0000_0000});
    tick();
    applyStimulus(0, 32'h8000_0000, 32'h0000_0004, ALU_SRA);
    @(negedge clk);
    checkOutput("sra_req_ready", 64'(req_ready), 64'h1);
    checkOutput("add_rsp_valid", 64'(rsp_valid), 64'h1);
    expQ[0].push_back({1'b0, 32'hF800_0000});
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("idle_alu_inp1", 64'(alu_inp1), 64'h0);
    checkOutput("idle_alu_inp2", 64'(alu_inp2), 64'h0);
    checkOutput("idle_alu_sel", 64'(alu_sel), 64'h0);
    checkOutput("idle_req_ready", 64'(req_ready), 64'h0);
    tick();

    // Reset while a result is held: it must vanish immediately.
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    applyStimulus(0, 32'h0000_FFFF, 32'h0000_0F0F, ALU_AND);
    @(negedge clk);
    checkOutput("held_req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    #2;
    checkOutput("held_rsp_valid", 64'(rsp_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("midreset_rsp_data", 64'(rsp_data), 64'h0);
    checkOutput("midreset_rsp_err", 64'(rsp_err), 64'h0);
    req_valid = 2'b11;
    #1;
    checkOutput("midreset_req_ready", 64'(req_ready), 64'h0);
    tick();

    // Contention: grants alternate starting from requester 0.
    rst_n     = 1'b1;
    rsp_ready = 2'b11;
    applyStimulus(0, 32'h0000_F0F0, 32'h0000_FF00, ALU_AND);
    applyStimulus(1, 32'h0000_0005, 32'h0000_0007, ALU_SUB);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("cont_grant%0d", c), 64'(req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      checkOutput($sformatf("cont_valid%0d", c), 64'(rsp_valid),
                  (c == 0) ? 64'h0 : ((c % 2 == 1) ? 64'h1 : 64'h2));
      if (c % 2 == 0) expQ[0].push_back({1'b0, 32'h0000_F000});
      else            expQ[1].push_back({1'b0, 32'hFFFF_FFFE});
      tick();
    end
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("cont_tail_valid", 64'(rsp_valid), 64'h2);
    tick();

    // Back-pressure on requester 1 while requester 0 streams.
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    applyStimulus(1, 32'h0000_00FF, 32'h0000_000F, ALU_XOR);
    @(negedge clk);
    checkOutput("bp_first_grant", 64'(req_ready), 64'h2);
    expQ[1].push_back({1'b0, 32'h0000_00F0});
    tick();
    req_valid = 2'b11;
    applyStimulus(0, 32'h0000_0001, 32'h0000_0002, ALU_OR);
    applyStimulus(1, 32'h0000_00AA, 32'h0000_0055, ALU_XOR);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_grant%0d", c), 64'(req_ready), 64'h1);
      checkOutput($sformatf("bp_held%0d", c), 64'(rsp_valid[1]), 64'h1);
      expQ[0].push_back({1'b0, 32'h0000_0003});
      tick();
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    checkOutput("bp_release_grant", 64'(req_ready), 64'h2);
    expQ[1].push_back({1'b0, 32'h0000_00FF});
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("bp_no_gap", 64'(rsp_valid[1]), 64'h1);
    tick();

    // Unsupported select flags an error; the next supported op clears it.
    req_valid = 2'b01;
    applyStimulus(0, 32'h0000_1234, 32'h0000_5678, 4'b1011);
    @(negedge clk);
    checkOutput("unsup_req_ready", 64'(req_ready), 64'h1);
    checkOutput("unsup_alu_sel", 64'(alu_sel), 64'hB);
    expQ[0].push_back({1'b1, 32'h0000_0000});
    tick();
    applyStimulus(0, 32'h0000_000C, 32'h0000_000A, ALU_AND);
    @(negedge clk);
    checkOutput("sup_req_ready", 64'(req_ready), 64'h1);
    expQ[0].push_back({1'b0, 32'h0000_0008});
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    tick();

    // Idle: outputs hold, pointer stays where the last grant left it.
    rsp_ready = 2'b00;
    tick();
    @(negedge clk);
    checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("hold_rsp_data0", 64'(rsp_data[XLEN-1:0]), 64'h8);
    checkOutput("hold_rsp_err0", 64'(rsp_err[0]), 64'h0);
    checkOutput("hold_alu_sel", 64'(alu_sel), 64'h0);
    tick();
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    applyStimulus(0, 32'h0000_0001, 32'h0000_0001, ALU_ADD);
    applyStimulus(1, 32'h0000_0003, 32'h0000_0003, ALU_ADD);
    @(negedge clk);
    checkOutput("ptr_held_grant", 64'(req_ready), 64'h2);
    expQ[1].push_back({1'b0, 32'h0000_0006});
    tick();
    req_valid = 2'b01;
    @(negedge clk);
    checkOutput("ptr_wrap_grant", 64'(req_ready), 64'h1);
    expQ[0].push_back({1'b0, 32'h0000_0002});
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    tick();
    @(negedge clk);
    checkOutput("expq0_drained", 64'(expQ[0].size()), 64'h0);
    checkOutput("expq1_drained", 64'(expQ[1].size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU between NREQ requesters, e.g. the EX-stage operand path and the branch-target/address-generation path.
- Round-robin arbitration, one operation issued per cycle.
- Per-requester valid/ready request and response channels.
- Registered, 1-cycle-latency result capture.
- Sits between the requesters and the ALU instance; the ALU inputs are driven only from this block.

Parameters:
NREQ, 2, number of requesters (2..4)
XLEN, 32, operand/result width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  request i presents an operation
req_ready  out  NREQ  request i accepted this cycle (one-hot or zero)
req_op1  in  NREQ*XLEN  operand 1 per requester, slice i = [i*XLEN +: XLEN] (rs1 or pc)
req_op2  in  NREQ*XLEN  operand 2 per requester (rs2 or imm)
req_sel  in  NREQ*4  ALU operation select per requester
rsp_valid  out  NREQ  result i held
rsp_ready  in  NREQ  requester i consumes result
rsp_data  out  NREQ*XLEN  result per requester
rsp_err  out  NREQ  result i came from an unsupported select code
alu_inp1  out  XLEN  to ALU inp1
alu_inp2  out  XLEN  to ALU inp2
alu_sel  out  4  to ALU ALUSel
alu_out  in  XLEN  from ALU out (combinational)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n. Assertion at any time immediately clears all state.
- Reset values:
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - Round-robin pointer = 0, so requester 0 has top priority first.
  - req_ready = 0 while rst_n low.
  - Any in-flight result is dropped; there is no replay.
- Eligibility: eligible[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). A full response slot may be refilled in the same cycle it drains.
- Grant:
  - One-hot among eligible requesters, searching from the pointer upward with wrap (pointer, pointer+1, ... mod NREQ).
  - req_ready = grant; it is combinational from req_valid, rsp_valid and rsp_ready.
  - Requesters must hold op1/op2/sel stable while valid and not ready.
- Pointer update: on any grant to k, pointer <= (k+1) mod NREQ. With no grant, the pointer holds.
- ALU drive:
  - With a grant, alu_inp1/alu_inp2/alu_sel = the granted requester's fields (combinational mux).
  - With no grant, all three are 0 (add of zeros).
- Capture (issue in cycle N, result visible in cycle N+1):
  - rsp_data[k] <= alu_out.
  - rsp_err[k] <= !supported(sel).
  - rsp_valid[k] <= 1.
- Supported select codes: 0000–1000 and 1010. For unsupported codes, rsp_data holds whatever the ALU produces (0) and rsp_err = 1.
- Drain: if rsp_valid[i] && rsp_ready[i] and no new capture for i, then rsp_valid[i] <= 0. rsp_data/rsp_err hold their last values.
- Simultaneous drain and capture on i: the new result replaces the old one, rsp_valid stays 1, and no bubble is inserted.
- Back-pressure: while rsp_valid[i] && !rsp_ready[i], requester i is not granted. Others proceed; starvation is impossible, since a stalled requester is skipped without moving the pointer.
- Throughput: one operation per cycle aggregate; one per cycle per requester when its response is drained every cycle.
- Width rules: no sign/zero extension in this block; operands pass through bit-exact.
- No combinational path from alu_out to any output; rsp_* are registered only.

Decomposition:
- Shared package alu_pkg:
  - ALUSel localparams: ALU_ADD 0000, ALU_SUB 0001, ALU_AND 0010, ALU_OR 0011, ALU_SLL 0100, ALU_SRL 0101, ALU_XOR 0110, ALU_SLT 0111, ALU_SLTU 1000, ALU_SRA 1010.
  - Function alu_sel_supported(sel).
  - Also used by the decoder.
- Sub-module rr_arbiter (parameter N):
  - Inputs: eligible vector, pointer.
  - Outputs: one-hot grant and next pointer.
  - Reusable for other shared resources.

Test Plan:
- Reset: rst_n low mid-operation (rsp_valid[0]=1) -> all rsp_valid=0, rsp_data=0, req_ready=0 immediately; after release, first grant goes to requester 0 when both request.
- Single issue: req0 valid, op1=0xFFFFFFF0, op2=0x10, sel=0000 -> req_ready[0]=1 cycle N; rsp_valid[0]=1, rsp_data[0]=0x00000000, rsp_err[0]=0 cycle N+1; SRA: op1=0x80000000, op2=4, sel=1010 -> 0xF8000000.
- Contention: both valid every cycle, rsp_ready=11 -> grants alternate 01,10,01,10; each rsp_valid pulses every other cycle with the matching result (req1 SUB 5-7 -> 0xFFFFFFFE).
- Back-pressure: rsp_ready[1]=0 with rsp_valid[1]=1, both requesting -> requester 0 granted every cycle, req_ready[1]=0; raise rsp_ready[1] -> req1 granted the same cycle, new result the next cycle with no gap in rsp_valid[1].
- Unsupported op: req0 sel=1011 -> rsp_err[0]=1, rsp_data[0]=0; the following sel=0010 on req0 -> rsp_err[0]=0.
- Idle: no valid -> alu_inp1/alu_inp2/alu_sel=0, pointer unchanged, rsp_* hold.
